// File: rtl/vector_sweep_capture.sv
// Sweeps a stimulus vector through all 2^N_BITS values, samples a 1-bit DUT
// response per vector, and buffers {stim, response} records in a FWFT FIFO.
module vector_sweep_capture #(
  parameter int N_BITS     = 3,
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  output logic [N_BITS-1:0] stim,
  input  logic              dut_out,
  output logic              rec_valid,
  output logic [N_BITS:0]   rec_data,
  input  logic              rec_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       signature
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int REC_W = N_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        cnt;
  logic [AW:0]       count, count_nx;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [REC_W-1:0]  mem [FIFO_DEPTH];
  logic              full, push, pop, stim_last;
  logic [REC_W-1:0]  rec_in;
  logic [15:0]       sig_nx;

  // Push decision looks only at start-of-cycle occupancy, so a same-cycle pop
  // never unblocks a stalled SAMPLE.
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign push      = (state == S_SAMPLE) && !full;
  assign rec_valid = (count != '0);
  assign pop       = rec_valid && rec_ready;
  assign stim_last = &stim;
  assign rec_in    = {stim, dut_out};
  assign rec_data  = mem[rd_ptr];
  assign sig_nx    = {signature[14:0], 1'b0}
                   ^ (signature[15] ? 16'h1021 : 16'h0000)
                   ^ 16'(rec_in);

  always_ff @(posedge CK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    count_nx = count;
    busy     = 1'b0;
    done     = 1'b0;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
    case (state)
      S_IDLE: if (start) state_nx = S_SETTLE;
      S_SETTLE: begin
        busy = 1'b1;
        if (cnt == 8'd1) state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy = 1'b1;
        if (push) state_nx = stim_last ? S_DRAIN : S_SETTLE;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (count_nx == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_SETTLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      stim      <= '0;
      cnt       <= '0;
      signature <= 16'h0000;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            stim      <= '0;
            cnt       <= 8'(SETTLE);
            signature <= 16'hFFFF;
          end
        end
        S_SETTLE: cnt <= cnt - 8'd1;
        S_SAMPLE: begin
          if (push) begin
            signature <= sig_nx;
            if (!stim_last) begin
              stim <= stim + 1'b1;
              cnt  <= 8'(SETTLE);
            end
          end
        end
        default: ;
      endcase
      count <= count_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the occupancy counter alone decides validity.
  always_ff @(posedge CK) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

endmodule

// File: tb/tb_vector_sweep_capture.sv
// Directed plus randomized bench for vector_sweep_capture; records and
// signatures are predicted from the sweep rules with a queue-based model.
module tb_vector_sweep_capture;
  localparam int NB = 3;
  localparam int NV = 1 << NB;

  logic          CK = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [NB-1:0] stim;
  logic          dut_out;
  logic          rec_valid;
  logic [NB:0]   rec_data;
  logic          rec_ready = 1'b0;
  logic          busy, done;
  logic [15:0]   signature;
  logic [NV-1:0] lut_bits = '0;

  logic          start_b = 1'b0;
  logic [0:0]    stim_b;
  logic          dut_out_b = 1'b0;
  logic          rec_valid_b;
  logic [1:0]    rec_data_b;
  logic          rec_ready_b = 1'b0;
  logic          busy_b, done_b;
  logic [15:0]   signature_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CK = ~CK;

  // Response truth table: the "DUT" answers lut_bits[stim].
  assign dut_out = lut_bits[stim];

  vector_sweep_capture #(.N_BITS(NB), .SETTLE(1), .FIFO_DEPTH(4)) u_dut (
    .CK(CK), .reset(reset), .start(start), .stim(stim), .dut_out(dut_out),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
    .busy(busy), .done(done), .signature(signature)
  );

  vector_sweep_capture #(.N_BITS(1), .SETTLE(3), .FIFO_DEPTH(2)) u_dut_b (
    .CK(CK), .reset(reset), .start(start_b), .stim(stim_b), .dut_out(dut_out_b),
    .rec_valid(rec_valid_b), .rec_data(rec_data_b), .rec_ready(rec_ready_b),
    .busy(busy_b), .done(done_b), .signature(signature_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sig_step(input logic [15:0] s, input int rec);
    logic [16:0] dbl;
    dbl = {1'b0, s} * 17'd2;
    return dbl[15:0] ^ (dbl[16] ? 16'h1021 : 16'h0000) ^ 16'(rec);
  endfunction

  // One full sweep on u_dut: ready asserted with probability prob% after the
  // first hold cycles; optional start pulse while busy.
  task automatic run_sweep(input int prob, input int hold, input bit glitch);
    int          q[$];
    logic [15:0] sig_m;
    bit          finished;
    bit          prev_hold;
    logic [NB:0] prev;
    sig_m     = 16'hFFFF;
    finished  = 1'b0;
    prev_hold = 1'b0;
    prev      = '0;
    for (int v = 0; v < NV; v++) begin
      q.push_back((v << 1) | int'(lut_bits[v]));
      sig_m = sig_step(sig_m, (v << 1) | int'(lut_bits[v]));
    end
    @(negedge CK);
    start = 1'b1;
    rec_ready = 1'b0;
    @(negedge CK);
    start = 1'b0;
    check("start_sig", signature, 16'hFFFF);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_stim", stim, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge CK);
      if (done === 1'b1) begin
        finished = 1'b1;
        break;
      end
      if (prev_hold) check("hold_stable", rec_data, prev);
      if (hold > 0 && cyc == hold) begin
        check("stall_stim", stim, 4);
        check("stall_valid", rec_valid, 1);
        check("stall_busy", busy, 1);
        check("stall_head", rec_data, q[0]);
      end
      start     = glitch && (cyc == 5);
      rec_ready = (cyc >= hold) && ($urandom_range(99) < prob);
      prev_hold = rec_valid && !rec_ready;
      prev      = rec_data;
      if (rec_valid && rec_ready) begin
        check("rec_expected", q.size() > 0, 1);
        if (q.size() > 0) check("rec_data", rec_data, q.pop_front());
      end
    end
    start = 1'b0;
    rec_ready = 1'b0;
    check("done_seen", finished, 1);
    check("all_recs", q.size(), 0);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_valid", rec_valid, 0);
    check("end_stim", stim, NV - 1);
    check("end_sig", signature, sig_m);
  endtask

  initial begin
    #3;
    check("rst_stim", stim, 0);
    check("rst_sig", signature, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge CK);
    reset = 1'b0;
    repeat (3) @(negedge CK);
    check("idle_busy", busy, 0);
    check("idle_stim", stim, 0);
    check("idle_valid", rec_valid, 0);

    // dut_out = stim[0], always ready
    lut_bits = 8'hAA;
    run_sweep(100, 0, 1'b0);

    // back-pressure: FIFO fills, stall at stim=100, then drain
    lut_bits = NV'($urandom);
    run_sweep(100, 20, 1'b0);

    // random ready, start pulsed mid-sweep; begins from DONE
    lut_bits = NV'($urandom);
    run_sweep(40, 0, 1'b1);

    // N_BITS=1, SETTLE=3 instance: hold time, glitch immunity, signature
    @(negedge CK);
    start_b = 1'b1;
    dut_out_b = 1'b1;
    rec_ready_b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CK);
      start_b = 1'b0;
      check("b_hold0", stim_b, 0);
      if (k == 4) dut_out_b = 1'b0;
    end
    @(negedge CK);
    check("b_stim1", stim_b, 1);
    check("b_rec0_valid", rec_valid_b, 1);
    check("b_rec0", rec_data_b, 2'b00);
    check("b_sig0", signature_b, 16'hEFDF);
    for (int k = 2; k <= 4; k++) begin
      @(negedge CK);
      check("b_hold1", stim_b, 1);
    end
    @(negedge CK);
    check("b_rec1_valid", rec_valid_b, 1);
    check("b_rec1", rec_data_b, 2'b10);
    check("b_sig1", signature_b, 16'hCF9D);
    @(negedge CK);
    check("b_done", done_b, 1);
    check("b_busy", busy_b, 0);
    check("b_sig_final", signature_b, 16'hCF9D);
    check("b_stim_final", stim_b, 1);
    rec_ready_b = 1'b0;

    // reset asserted mid-sweep at stim=010
    lut_bits = NV'($urandom);
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (stim === 3'b010) break;
      @(negedge CK);
    end
    check("reach_010", stim, 2);
    #2 reset = 1'b1;
    #1;
    check("async_stim", stim, 0);
    check("async_sig", signature, 0);
    check("async_valid", rec_valid, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    @(negedge CK);
    reset = 1'b0;
    repeat (3) @(negedge CK);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", rec_valid, 0);
    run_sweep(70, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vector_sweep_capture.md
VECTOR_SWEEP_CAPTURE -- requirements
Module: vector_sweep_capture

Interface
REQ-001 Parameter N_BITS, default 3, width of the stimulus vector driven to the DUT (1..16).
REQ-002 Parameter SETTLE, default 1, number of cycles each vector is held before the response is sampled (1..255).
REQ-003 Parameter FIFO_DEPTH, default 4, number of record entries in the output buffer (power of 2, at least 2).
REQ-004 CK  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sweep; sampled only in IDLE or DONE.
REQ-007 stim  output  N_BITS  stimulus vector to the DUT; stim[N_BITS-1] is the MSB.
REQ-008 dut_out  input  1  single-bit DUT response.
REQ-009 rec_valid  output  1  record available at the FIFO head.
REQ-010 rec_data  output  N_BITS+1  record {stim, response}; response is the LSB.
REQ-011 rec_ready  input  1  consumer accepts the record when rec_valid and rec_ready are both high.
REQ-012 busy  output  1  high in SETTLE, SAMPLE and DRAIN.
REQ-013 done  output  1  high in DONE.
REQ-014 signature  output  16  running response signature.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, SAMPLE, DRAIN and DONE.
REQ-016 IDLE/DONE + start=1: set stim to 0, load the settle counter with SETTLE, load signature with 16'hFFFF, clear done, and go to SETTLE.
REQ-017 SETTLE: stim is held and the counter decrements each cycle; when the counter is 1, go to SAMPLE, so each vector is held exactly SETTLE cycles before sampling.
REQ-018 SAMPLE with FIFO not full: push {stim, dut_out} and update signature. Then either go to DRAIN if stim is all ones, or increment stim, reload the counter and go to SETTLE.
REQ-019 SAMPLE with FIFO full: stall in SAMPLE with stim held and no push; the push decision uses the occupancy at the start of the cycle, so a same-cycle pop does not unblock it.
REQ-020 Unstalled throughput is SETTLE+1 cycles per vector; a sweep covers all 2^N_BITS vectors in ascending order, with no gaps and no repeats.
REQ-021 Signature update on each push: sig_next = (sig<<1, truncated to 16 bits) XOR (sig[15] ? 16'h1021 : 0) XOR (the record zero-extended to 16 bits).
REQ-022 FIFO: registered first-word-fall-through; rec_valid goes high the cycle after the first push; rec_data is stable while rec_valid=1 and rec_ready=0; push and pop in the same cycle keep occupancy unchanged.
REQ-023 DRAIN: go to DONE on the cycle the FIFO becomes empty, meaning the final record has been popped.
REQ-024 DONE: done=1, stim holds all ones and signature holds the final value until the next start.
REQ-025 start is ignored while busy=1.
REQ-026 dut_out is consumed only in SAMPLE cycles that push.

Reset
REQ-027 An asserted reset SHALL, without waiting for a clock edge, force state to IDLE, stim to 0, signature to 16'h0000, FIFO to empty, and rec_valid, busy and done to 0.
REQ-028 A reset asserted mid-sweep SHALL discard all buffered records; no record or partial signature appears after reset is released.
REQ-029 After reset is released, the block SHALL remain in IDLE until start=1.

Verification
REQ-030 N_BITS=3, SETTLE=1, dut_out wired to stim[0], rec_ready=1, start pulse -> rec_data sequence 0000, 0011, 0100, 0111, 1000, 1011, 1100, 1111, then done=1 and busy=0.
REQ-031 N_BITS=1, dut_out=0, rec_ready=1 -> records 00 then 10; signature EFDF after the first push and CF9D in DONE.
REQ-032 rec_ready=0 throughout the sweep, FIFO_DEPTH=4 -> exactly 4 records buffered, FSM stalled in SAMPLE with stim=3'b100; rec_ready then raised -> remaining vectors captured in order, with no loss or duplication.
REQ-033 SETTLE=3 -> stim holds each value for exactly 4 cycles; dut_out is sampled on the 4th cycle, and a glitch on dut_out in the first 3 cycles has no effect on the record.
REQ-034 Reset asserted while stim=3'b010 -> stim, signature and rec_valid are immediately 0; a following start produces a full 8-record sweep from 000.
REQ-035 start pulsed again mid-sweep -> ignored; start in DONE -> a new sweep begins and signature restarts from FFFF.
